// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and port indices.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/dmem_rr_select.sv
// Requester selection for the data-memory arbiter.
// Default: round-robin, the port that did not win last time wins a tie.
// DMEM_ARB_FIXED_PRIO_EN: the core port always wins a tie and `last` is ignored.
module dmem_rr_select
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       any
);

  assign any = |req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // Core wins whenever it asks.
  assign sel = req[0] ? PORT_CORE : PORT_AUX;
`else
  // Single requester wins outright; on a tie the port that was not granted last wins.
  always_comb begin
    sel = PORT_CORE;
    if (req == 2'b11) begin
      sel = ~last;
    end else if (req[1]) begin
      sel = PORT_AUX;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data RAM.
// Port 0 is the core, port 1 the loader/debug master. Each access takes an
// ISSUE cycle (grant + RAM command) and a RESP cycle (read data returned).
// Macro DMEM_ARB_FIXED_PRIO_EN selects fixed core priority instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]        req;
  logic              sel;
  logic              any;
  logic              last;
  logic              owner;
  state_t            state;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  assign req = {m1_req, m0_req};

  dmem_rr_select u_select (
    .req  (req),
    .last (last),
    .sel  (sel),
    .any  (any)
  );

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign last = PORT_AUX;
`else
  // Remember the most recently granted port for the next tie-break.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_AUX;
    end else if (state != ST_ISSUE && any) begin
      last <= sel;
    end
  end
`endif

  // Access sequencer: grant and RAM command are registered on entry to ISSUE,
  // since requester inputs are stable from req rise through the grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= PORT_CORE;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      hold0     <= '0;
      hold1     <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;

      if (m0_rvalid) hold0 <= mem_dout;
      if (m1_rvalid) hold1 <= mem_dout;

      case (state)
        ST_IDLE, ST_RESP: begin
          if (any) begin
            state    <= ST_ISSUE;
            owner    <= sel;
            m0_gnt   <= (sel == PORT_CORE);
            m1_gnt   <= (sel == PORT_AUX);
            mem_we   <= (sel == PORT_AUX) ? m1_we    : m0_we;
            mem_addr <= (sel == PORT_AUX) ? m1_addr  : m0_addr;
            mem_din  <= (sel == PORT_AUX) ? m1_wdata : m0_wdata;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state     <= ST_RESP;
          m0_rvalid <= (owner == PORT_CORE) && !mem_we;
          m1_rvalid <= (owner == PORT_AUX) && !mem_we;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM data arrives in the RESP cycle; pass it through and hold it afterwards.
  assign m0_rdata = m0_rvalid ? mem_dout : hold0;
  assign m1_rdata = m1_rvalid ? mem_dout : hold1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: synchronous RAM model, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port RAM: read data one cycle after the address.
  logic [31:0] ram [512];
  initial begin
    for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
    mem_dout <= '0;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // Winner when a new access may start.
  function automatic bit pick(input logic [1:0] r, input bit last);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    return (r[0] || last) ? !r[0] : 1'b1;
`else
    if (r == 2'b11) return !last;
    return r[1];
`endif
  endfunction

  // Reference model: an access occupies the memory for two cycles (issue, then
  // response); a new access may start at any edge not ending an issue cycle.
  logic [1:0]  e_gnt = '0, e_rv = '0;
  logic        e_we = 1'b0;
  logic [8:0]  e_addr = '0;
  logic [31:0] e_din = '0, e_rdata = '0, m_data = '0;
  logic [31:0] shadow [int];
  bit          m_valid = 1'b0, m_resp = 1'b0, m_port = 1'b0, m_rd = 1'b0, m_last = 1'b1;

  always @(posedge clk) begin
    logic [1:0] r;
    bit         w;
    r = {m1_req, m0_req};
    e_gnt = '0; e_rv = '0; e_we = 1'b0; e_addr = '0; e_din = '0;
    if (rst) begin
      m_resp = 1'b0;
      m_last = 1'b1;
    end else if (m_resp) begin
      m_resp = 1'b0;
      if (m_rd) begin
        e_rv[m_port] = 1'b1;
        e_rdata = m_data;
      end
    end else if (r != 2'b00) begin
      w = pick(r, m_last);
      m_last = w; m_port = w; m_resp = 1'b1;
      e_gnt[w] = 1'b1;
      e_we   = w ? m1_we    : m0_we;
      e_addr = w ? m1_addr  : m0_addr;
      e_din  = w ? m1_wdata : m0_wdata;
      m_rd   = !e_we;
      if (e_we) shadow[int'(e_addr)] = e_din;
      else m_data = shadow.exists(int'(e_addr)) ? shadow[int'(e_addr)] : init_word(int'(e_addr));
    end
    m_valid = 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m0_gnt",    32'(m0_gnt),    32'(e_gnt[0]));
      chk("m1_gnt",    32'(m1_gnt),    32'(e_gnt[1]));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_din",   mem_din,        e_din);
      if (e_rv[0]) chk("m0_rdata", m0_rdata, e_rdata);
      if (e_rv[1]) chk("m1_rdata", m1_rdata, e_rdata);
    end
  end

  initial begin
    logic [3:0] x_g0, x_g1, x_rv0, x_rv1;
    int         gports[$];
    int         gcycles[$];

    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle.
    @(negedge clk);
    chk("reset_rdata0", m0_rdata, 32'h0);
    chk("reset_rdata1", m1_rdata, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_gnt",    32'({m1_gnt, m0_gnt}), 32'h0);
      chk("idle_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
      chk("idle_mem_we", 32'(mem_we), 32'h0);
    end

    // Port 0 write then read back.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h010; m0_wdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    chk("wr_m0_gnt",   32'(m0_gnt), 32'h1);
    chk("wr_mem_we",   32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h010);
    chk("wr_mem_din",  mem_din, 32'hDEADBEEF);
    @(posedge clk); #1 m0_req = 1'b0; m0_we = 1'b0;
    @(negedge clk);
    chk("wr_no_rvalid", 32'(m0_rvalid), 32'h0);
    @(posedge clk); #1 m0_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rd_m0_gnt", 32'(m0_gnt), 32'h1);
    chk("rd_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk);
    chk("rd_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("rd_m0_rdata",  m0_rdata, 32'hDEADBEEF);

    // Simultaneous first request after reset: port 0 first.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m0_req = 1'b1; m0_addr = 9'h004;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h008;
    x_g0 = 4'b0001; x_rv0 = 4'b0010; x_g1 = 4'b0100; x_rv1 = 4'b1000;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sim_m0_gnt",    32'(m0_gnt),    32'(x_g0[k]));
      chk("sim_m1_gnt",    32'(m1_gnt),    32'(x_g1[k]));
      chk("sim_m0_rvalid", 32'(m0_rvalid), 32'(x_rv0[k]));
      chk("sim_m1_rvalid", 32'(m1_rvalid), 32'(x_rv1[k]));
      if (k == 1) chk("sim_m0_rdata", m0_rdata, 32'hA500_0004);
      if (k == 3) chk("sim_m1_rdata", m1_rdata, 32'hA500_0008);
      @(posedge clk); #1;
      if (k == 0) m0_req = 1'b0;
      if (k == 2) m1_req = 1'b0;
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Continuous contention: grants alternate, one every two cycles.
    m0_req = 1'b1; m0_addr = 9'h020;
    m1_req = 1'b1; m1_addr = 9'h030;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) begin
        @(posedge clk); #1 m0_req = 1'b0; m1_req = 1'b0;
      end
      @(negedge clk);
      if (m0_gnt && m1_gnt) chk("cont_both_gnt", 32'h1, 32'h0);
      if (m0_gnt) begin gports.push_back(0); gcycles.push_back(k); end
      if (m1_gnt) begin gports.push_back(1); gcycles.push_back(k); end
    end
    chk("cont_count", 32'(gports.size()), 32'd6);
    for (int i = 0; i < gports.size() && i < 6; i++) begin
      chk("cont_port",  32'(gports[i]),  32'(i % 2));
      chk("cont_cycle", 32'(gcycles[i]), 32'(2 * i + 1));
    end
`endif

    // Reset during the issue cycle of a port 1 read.
    @(posedge clk); #1 m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h040;
    @(posedge clk); @(negedge clk);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'h1);
    rst = 1'b1; m1_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_no_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
    chk("rst_no_gnt",    32'({m1_gnt, m0_gnt}), 32'h0);
    chk("rst_mem_addr",  32'(mem_addr), 32'h0);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h010;
    @(posedge clk); @(negedge clk);
    chk("post_rst_m0_gnt", 32'(m0_gnt), 32'h1);
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(m0_rvalid), 32'h1);
    chk("post_rst_rdata",  m0_rdata, 32'hDEADBEEF);

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 was granted last, so port 1's write wins the tie and port 0 reads it.
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h050; m1_wdata = 32'h1234_5678;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h050;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("raw_m1_first", 32'(m1_gnt), 32'h1);
      if (k == 2) chk("raw_m0_second", 32'(m0_gnt), 32'h1);
      if (k == 3) begin
        chk("raw_m0_rvalid", 32'(m0_rvalid), 32'h1);
        chk("raw_m0_rdata",  m0_rdata, 32'h1234_5678);
      end
      @(posedge clk); #1;
      if (k == 0) begin m1_req = 1'b0; m1_we = 1'b0; end
      if (k == 2) m0_req = 1'b0;
    end
`else
    // Fixed priority: port 1 is starved while port 0 keeps asking.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 9'h020;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h030;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fixed_no_m1_gnt", 32'(m1_gnt), 32'h0);
    end
    @(posedge clk); #1 m0_req = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        @(negedge clk);
        if (m1_gnt) seen = 1'b1;
      end
      chk("fixed_m1_gnt_after_drop", 32'(seen), 32'h1);
    end
    @(posedge clk); #1 m1_req = 1'b0;
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
